// File: rtl/max_search_ctrl.sv
// Frame maximum search: elements stream into a 4-lane buffer, each full (or final
// partial) group is reduced in a single COMPARE cycle against the running maximum.
module max_search_ctrl #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [LEN_W-1:0]  out_idx,
  output logic              out_empty,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: an element moves when in_valid && in_ready (in_ready only in LOAD);
  // a result moves when out_valid && out_ready (out_valid only in DONE).
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t              r_state;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_lane_data [4];
  logic [LEN_W-1:0]    r_lane_idx  [4];
  logic [3:0]          r_lane_vld;
  logic [DATA_W-1:0]   r_run_max;
  logic [LEN_W-1:0]    r_run_idx;
  logic                r_run_vld;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_max;
  logic [LEN_W-1:0]    r_out_idx;
  logic                r_out_empty;
  logic                r_busy;

  logic                w_xfer;
  logic [1:0]          w_lane;
  logic                w_last;
  logic [DATA_W-1:0]   w_best_max;
  logic [LEN_W-1:0]    w_best_idx;
  logic                w_best_vld;

  assign w_xfer = in_valid && r_in_ready;
  assign w_lane = r_cnt[1:0];
  assign w_last = (r_cnt == (r_len - ONE));

  // Running max holds earlier indices and lanes are in index order, so a strict
  // greater-than keeps the lowest index on ties.
  always_comb begin
    w_best_max = r_run_max;
    w_best_idx = r_run_idx;
    w_best_vld = r_run_vld;
    for (int i = 0; i < 4; i++) begin
      if (r_lane_vld[i] && (!w_best_vld || (r_lane_data[i] > w_best_max))) begin
        w_best_max = r_lane_data[i];
        w_best_idx = r_lane_idx[i];
        w_best_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_lane_vld  <= '0;
      r_run_max   <= '0;
      r_run_idx   <= '0;
      r_run_vld   <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_max   <= '0;
      r_out_idx   <= '0;
      r_out_empty <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_lane_data[i] <= '0;
        r_lane_idx[i]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (len != '0) begin
              r_state    <= S_LOAD;
              r_len      <= len;
              r_cnt      <= '0;
              r_run_vld  <= 1'b0;
              r_run_max  <= '0;
              r_run_idx  <= '0;
              r_in_ready <= 1'b1;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_empty <= 1'b1;
              r_out_max   <= '0;
              r_out_idx   <= '0;
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_lane_data[w_lane] <= in_data;
            r_lane_idx[w_lane]  <= r_cnt;
            r_lane_vld[w_lane]  <= 1'b1;
            r_cnt               <= r_cnt + ONE;
            if ((w_lane == 2'd3) || w_last) begin
              r_state    <= S_COMPARE;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_COMPARE: begin
          r_run_max  <= w_best_max;
          r_run_idx  <= w_best_idx;
          r_run_vld  <= w_best_vld;
          r_lane_vld <= '0;
          if (r_cnt != r_len) begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
          end else begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_max   <= w_best_max;
            r_out_idx   <= w_best_idx;
            r_out_empty <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_max   <= '0;
            r_out_idx   <= '0;
            r_out_empty <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_max   = r_out_max;
  assign out_idx   = r_out_idx;
  assign out_empty = r_out_empty;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_max_search_ctrl.sv
// Directed bench for max_search_ctrl: hand-computed frames, latency, hold and reset cases.
module tb_max_search_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_max;
  logic [7:0] out_idx;
  logic       out_empty;
  logic       busy;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  max_search_ctrl #(.DATA_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_idx(out_idx), .out_empty(out_empty), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Offer one element; wait a bounded number of cycles for in_ready.
  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) break;
      tick();
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL send_timeout: in_ready=%b required 1 for data %0h", in_ready, d);
    end else begin
      n_pass++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Checks the cycle after the final transfer (COMPARE) and the following DONE cycle.
  task automatic check_result(input string name, input logic [7:0] e_max, input logic [7:0] e_idx);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL %s_lat_compare: out_valid=%b required 0", name, out_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL %s_lat_done: out_valid=%b required 1", name, out_valid);
    else n_pass++;
    n_checks++;
    if (out_max !== e_max) $display("FAIL %s_max: out_max=%0h required %0h", name, out_max, e_max);
    else n_pass++;
    n_checks++;
    if (out_idx !== e_idx) $display("FAIL %s_idx: out_idx=%0d required %0d", name, out_idx, e_idx);
    else n_pass++;
    n_checks++;
    if (out_empty !== 1'b0) $display("FAIL %s_empty: out_empty=%b required 0", name, out_empty);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, out_empty, busy, out_max, out_idx} !== 20'h0)
      $display("FAIL reset_outputs: rdy=%b vld=%b emp=%b busy=%b max=%0h idx=%0d required all 0",
               in_ready, out_valid, out_empty, busy, out_max, out_idx);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] d [4] = '{8'h12, 8'hF0, 8'h07, 8'h33};
    start_frame(8'd4);
    n_checks++;
    if ({busy, in_ready} !== 2'b11) $display("FAIL basic_load: busy,in_ready=%b required 11", {busy, in_ready});
    else n_pass++;
    for (int i = 0; i < 4; i++) send(d[i]);
    check_result("basic", 8'hF0, 8'd1);
    release_result();
    n_checks++;
    if ({out_valid, busy, out_max, out_idx} !== 18'h0)
      $display("FAIL basic_release: vld=%b busy=%b max=%0h idx=%0d required all 0", out_valid, busy, out_max, out_idx);
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic [7:0] d [6] = '{8'd5, 8'd9, 8'd9, 8'd1, 8'd9, 8'd2};
    start_frame(8'd6);
    for (int i = 0; i < 6; i++) begin
      send(d[i]);
      if (i < 5) for (int g = 0; g < (i % 3); g++) tick();
    end
    check_result("gaps", 8'd9, 8'd1);
    release_result();
  endtask

  task automatic test_empty();
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL empty_pre_ready: in_ready=%b required 0", in_ready);
    else n_pass++;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    start_frame(8'd0);
    n_checks++;
    if ({out_valid, out_empty, in_ready} !== 3'b110)
      $display("FAIL empty_flags: vld,emp,rdy=%b required 110", {out_valid, out_empty, in_ready});
    else n_pass++;
    n_checks++;
    if ({out_max, out_idx} !== 16'h0) $display("FAIL empty_data: max=%0h idx=%0d required 0", out_max, out_idx);
    else n_pass++;
    release_result();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b000)
      $display("FAIL empty_release: vld,busy,rdy=%b required 000", {out_valid, busy, in_ready});
    else n_pass++;
  endtask

  task automatic test_hold();
    start_frame(8'd1);
    send(8'h00);
    check_result("hold", 8'h00, 8'd0);
    for (int k = 0; k < 10; k++) begin
      start    = (k % 2 == 0);
      len      = 8'd5;
      in_valid = 1'b1;
      in_data  = 8'h77;
      tick();
      n_checks++;
      if ({out_valid, out_empty, busy, in_ready, out_max, out_idx} !== {4'b1010, 16'h0})
        $display("FAIL hold_stable_%0d: vld=%b emp=%b busy=%b rdy=%b max=%0h idx=%0d", k,
                 out_valid, out_empty, busy, in_ready, out_max, out_idx);
      else n_pass++;
    end
    start = 1'b0; in_valid = 1'b0;
    release_result();
    tick();
    n_checks++;
    if ({busy, out_valid, in_ready} !== 3'b000)
      $display("FAIL hold_start_ignored: busy,vld,rdy=%b required 000", {busy, out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    logic [7:0] d [3] = '{8'hFF, 8'h01, 8'hFF};
    start_frame(8'd8);
    for (int i = 0; i < 5; i++) send(8'h80 + 8'(i));
    rst = 1'b1; start = 1'b1; len = 8'd2; out_ready = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, out_empty, busy, out_max, out_idx} !== 20'h0)
      $display("FAIL rst_mid_outputs: rdy=%b vld=%b emp=%b busy=%b max=%0h idx=%0d required all 0",
               in_ready, out_valid, out_empty, busy, out_max, out_idx);
    else n_pass++;
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if ({out_valid, in_ready, busy} !== 3'b000)
        $display("FAIL rst_mid_quiet_%0d: vld,rdy,busy=%b required 000", k, {out_valid, in_ready, busy});
      else n_pass++;
    end
    in_valid = 1'b0;
    start_frame(8'd3);
    for (int i = 0; i < 3; i++) send(d[i]);
    check_result("rst_new", 8'hFF, 8'd0);
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a [4] = '{8'd1, 8'd2, 8'd3, 8'd200};
    logic [7:0] c [5] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    start_frame(8'd4);
    for (int i = 0; i < 4; i++) send(a[i]);
    check_result("b2b_a", 8'd200, 8'd3);
    release_result();
    start_frame(8'd2);
    send(8'd5);
    send(8'd6);
    check_result("b2b_b", 8'd6, 8'd1);
    release_result();
    start_frame(8'd5);
    for (int i = 0; i < 5; i++) send(c[i]);
    check_result("b2b_c", 8'd50, 8'd4);
    release_result();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_empty();
    test_hold();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
